dual_issue_ctrl: RTL and testbench

- Issue and hazard controller for the dual-issue (master/slave) pipeline.
- Decides each cycle whether the decoded pair issues as 0, 1 or 2 instructions.
- Generates the enables and clears for every pipeline register (F, D, ID/EX master/slave halves, M, W), covering load-use hazards, multi-cycle divide stalls, cache stalls and exception flushes.
- Includes a pending-flush latch, so an exception raised during a memory stall is not lost.

---
 rtl/dual_issue_ctrl_pkg.sv | 22 ++
 rtl/dual_issue_ctrl_pair_check.sv | 56 +++++
 rtl/dual_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dual_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl_pkg
// Purpose  : Shared types and constants for the dual-issue pipeline controller.
// Contents : state_e (RUN/DIV), D_consume encodings, register-zero constant.
// Revision : 1.0 - initial release
// ============================================================================
package dual_issue_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_DIV = 1'b1
    } state_e;

    localparam logic [1:0] CONS_NONE = 2'd0;
    localparam logic [1:0] CONS_ONE  = 2'd1;
    localparam logic [1:0] CONS_TWO  = 2'd2;

    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage : dual_issue_ctrl_pkg
`default_nettype wire

// File: rtl/dual_issue_ctrl_pair_check.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl_pair_check
// Purpose  : Combinational dual-issue eligibility of the decoded pair.
// Ports    : slot valids, slave sources, master destination, EX-stage load
//            destination, resource/slot-type flags in; dual_o out.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl_pair_check
    import dual_issue_ctrl_pkg::*;
#(
    parameter int ALLOW_DUAL = 1
) (
    input  logic       master_valid_i,
    input  logic       slave_valid_i,
    input  logic [4:0] slave_rs_i,
    input  logic [4:0] slave_rt_i,
    input  logic [4:0] master_reg_waddr_i,
    input  logic       master_reg_wen_i,
    input  logic       master_mem_en_i,
    input  logic       slave_mem_en_i,
    input  logic       master_hilo_i,
    input  logic       slave_hilo_i,
    input  logic       slave_is_branch_i,
    input  logic       slave_priv_i,
    input  logic       e_memread_i,
    input  logic [4:0] e_reg_waddr_i,
    output logic       dual_o
);

    logic w_raw;
    logic w_slave_load_use;
    logic w_resource;
    logic w_slot_type;

    // Slave may not consume a result its partner produces in the same cycle.
    assign w_raw = master_reg_wen_i && (master_reg_waddr_i != REG_ZERO) &&
                   ((slave_rs_i == master_reg_waddr_i) ||
                    (slave_rt_i == master_reg_waddr_i));

    assign w_slave_load_use = e_memread_i && (e_reg_waddr_i != REG_ZERO) &&
                              ((slave_rs_i == e_reg_waddr_i) ||
                               (slave_rt_i == e_reg_waddr_i));

    // Only one memory port and one HI/LO unit exist.
    assign w_resource  = (master_mem_en_i && slave_mem_en_i) ||
                         (master_hilo_i && slave_hilo_i);

    // Branches and privileged ops must occupy the master slot.
    assign w_slot_type = slave_is_branch_i || slave_priv_i;

    assign dual_o = (ALLOW_DUAL != 0) && master_valid_i && slave_valid_i &&
                    !w_raw && !w_slave_load_use && !w_resource && !w_slot_type;

endmodule : dual_issue_ctrl_pair_check
`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl
// Purpose  : Issue/hazard controller for the master/slave dual-issue pipeline.
//            Produces enables/clears for F, D, ID/EX (master/slave), M, W and
//            the number of instructions consumed from decode each cycle.
// Ports    : clk, rst (sync, active-high); decode-slot descriptors, EX load
//            and divide status, cache stalls, exception flush in;
//            pipeline enables/clears, D_consume, dual_issue, div_timeout out.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int ALLOW_DUAL  = 1,
    parameter int DIV_MAX_CYC = 40,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D_master_valid,
    input  logic       D_slave_valid,
    input  logic [4:0] D_master_rs,
    input  logic [4:0] D_master_rt,
    input  logic [4:0] D_slave_rs,
    input  logic [4:0] D_slave_rt,
    input  logic [4:0] D_master_reg_waddr,
    input  logic       D_master_reg_wen,
    input  logic       D_master_mem_en,
    input  logic       D_slave_mem_en,
    input  logic       D_master_hilo,
    input  logic       D_slave_hilo,
    input  logic       D_slave_is_branch,
    input  logic       D_slave_priv,
    input  logic       E_master_memRead,
    input  logic [4:0] E_master_reg_waddr,
    input  logic       E_div_start,
    input  logic       div_done,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       M_except_flush,
    output logic       F_ena,
    output logic       D_ena,
    output logic       D_clear,
    output logic       ena1,
    output logic       ena2,
    output logic       clear1,
    output logic       clear2,
    output logic       M_ena,
    output logic       M_clear,
    output logic       W_ena,
    output logic [1:0] D_consume,
    output logic       dual_issue,
    output logic       div_timeout
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DIV_MAX_CYC);

    state_e            state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic              div_timeout_q, div_timeout_d;

    logic w_dual;
    logic w_cache_stall;
    logic w_flush_now;
    logic w_global_stall;
    logic w_load_use;

    dual_issue_ctrl_pair_check #(
        .ALLOW_DUAL (ALLOW_DUAL)
    ) u_pair_check (
        .master_valid_i     (D_master_valid),
        .slave_valid_i      (D_slave_valid),
        .slave_rs_i         (D_slave_rs),
        .slave_rt_i         (D_slave_rt),
        .master_reg_waddr_i (D_master_reg_waddr),
        .master_reg_wen_i   (D_master_reg_wen),
        .master_mem_en_i    (D_master_mem_en),
        .slave_mem_en_i     (D_slave_mem_en),
        .master_hilo_i      (D_master_hilo),
        .slave_hilo_i       (D_slave_hilo),
        .slave_is_branch_i  (D_slave_is_branch),
        .slave_priv_i       (D_slave_priv),
        .e_memread_i        (E_master_memRead),
        .e_reg_waddr_i      (E_master_reg_waddr),
        .dual_o             (w_dual)
    );

    assign w_cache_stall  = i_stall || d_stall;
    // A flush cannot take effect while a cache transaction is in flight.
    assign w_flush_now    = (M_except_flush || flush_pend_q) && !w_cache_stall;
    assign w_global_stall = w_cache_stall || (state_q == ST_DIV);
    assign w_load_use     = E_master_memRead && (E_master_reg_waddr != REG_ZERO) &&
                            ((E_master_reg_waddr == D_master_rs) ||
                             (E_master_reg_waddr == D_master_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_pend_q  <= 1'b0;
            div_cnt_q     <= '0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_pend_q  <= flush_pend_d;
            div_cnt_q     <= div_cnt_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    // Next-state: flush overrides everything, including a pending div_done.
    always_comb begin
        state_d       = state_q;
        flush_pend_d  = flush_pend_q;
        div_cnt_d     = div_cnt_q;
        div_timeout_d = div_timeout_q;
        if (w_flush_now) begin
            state_d      = ST_RUN;
            flush_pend_d = 1'b0;
            div_cnt_d    = '0;
        end else begin
            if (M_except_flush && w_cache_stall) begin
                flush_pend_d = 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    // Entry deferred while a cache stall holds EX in place.
                    if (E_div_start && !w_cache_stall) begin
                        state_d = ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_d   = ST_RUN;
                        div_cnt_d = '0;
                    end else if (div_cnt_q != c_CNT_MAX) begin
                        div_cnt_d = div_cnt_q + 1'b1;
                        if (div_cnt_q + 1'b1 == c_CNT_MAX) begin
                            div_timeout_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        F_ena      = 1'b0;
        D_ena      = 1'b0;
        D_clear    = 1'b0;
        ena1       = 1'b0;
        ena2       = 1'b0;
        clear1     = 1'b0;
        clear2     = 1'b0;
        M_ena      = 1'b0;
        M_clear    = 1'b0;
        W_ena      = 1'b0;
        D_consume  = CONS_NONE;
        dual_issue = 1'b0;
        if (rst) begin
            D_clear = 1'b1;
            clear1  = 1'b1;
            clear2  = 1'b1;
            M_clear = 1'b1;
        end else if (w_flush_now) begin
            D_clear = 1'b1;
            clear1  = 1'b1;
            clear2  = 1'b1;
            M_clear = 1'b1;
            F_ena   = 1'b1;
            W_ena   = 1'b1;
        end else if (w_global_stall) begin
            // Freeze every stage.
        end else if (w_load_use) begin
            // Hold F/D, inject a bubble into EX, let older work drain.
            clear1 = 1'b1;
            clear2 = 1'b1;
            M_ena  = 1'b1;
            W_ena  = 1'b1;
        end else begin
            F_ena = 1'b1;
            D_ena = 1'b1;
            ena1  = 1'b1;
            M_ena = 1'b1;
            W_ena = 1'b1;
            if (w_dual) begin
                ena2       = 1'b1;
                D_consume  = CONS_TWO;
                dual_issue = 1'b1;
            end else begin
                clear2    = 1'b1;
                D_consume = CONS_ONE;
            end
            if (!D_master_valid) begin
                clear1    = 1'b1;
                D_consume = CONS_NONE;
            end
        end
    end

    assign div_timeout = div_timeout_q;

endmodule : dual_issue_ctrl
`default_nettype wire

// File: tb/tb_dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_ctrl
// Purpose  : Scoreboard bench for dual_issue_ctrl: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_ctrl;

    localparam int c_DIV_MAX = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       D_master_valid, D_slave_valid;
    logic [4:0] D_master_rs, D_master_rt, D_slave_rs, D_slave_rt;
    logic [4:0] D_master_reg_waddr;
    logic       D_master_reg_wen;
    logic       D_master_mem_en, D_slave_mem_en;
    logic       D_master_hilo, D_slave_hilo;
    logic       D_slave_is_branch, D_slave_priv;
    logic       E_master_memRead;
    logic [4:0] E_master_reg_waddr;
    logic       E_div_start, div_done;
    logic       i_stall, d_stall, M_except_flush;
    logic       F_ena, D_ena, D_clear, ena1, ena2, clear1, clear2;
    logic       M_ena, M_clear, W_ena;
    logic [1:0] D_consume;
    logic       dual_issue, div_timeout;

    always #5 clk = ~clk;

    dual_issue_ctrl #(
        .ALLOW_DUAL  (1),
        .DIV_MAX_CYC (c_DIV_MAX),
        .CNT_W       (6)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .D_master_valid     (D_master_valid),
        .D_slave_valid      (D_slave_valid),
        .D_master_rs        (D_master_rs),
        .D_master_rt        (D_master_rt),
        .D_slave_rs         (D_slave_rs),
        .D_slave_rt         (D_slave_rt),
        .D_master_reg_waddr (D_master_reg_waddr),
        .D_master_reg_wen   (D_master_reg_wen),
        .D_master_mem_en    (D_master_mem_en),
        .D_slave_mem_en     (D_slave_mem_en),
        .D_master_hilo      (D_master_hilo),
        .D_slave_hilo       (D_slave_hilo),
        .D_slave_is_branch  (D_slave_is_branch),
        .D_slave_priv       (D_slave_priv),
        .E_master_memRead   (E_master_memRead),
        .E_master_reg_waddr (E_master_reg_waddr),
        .E_div_start        (E_div_start),
        .div_done           (div_done),
        .i_stall            (i_stall),
        .d_stall            (d_stall),
        .M_except_flush     (M_except_flush),
        .F_ena              (F_ena),
        .D_ena              (D_ena),
        .D_clear            (D_clear),
        .ena1               (ena1),
        .ena2               (ena2),
        .clear1             (clear1),
        .clear2             (clear2),
        .M_ena              (M_ena),
        .M_clear            (M_clear),
        .W_ena              (W_ena),
        .D_consume          (D_consume),
        .dual_issue         (dual_issue),
        .div_timeout        (div_timeout)
    );

    int errors = 0;
    int checks = 0;

    // {F,D,Dclr,e1,e2,c1,c2,Me,Mc,We,cons[1:0],dual,timeout}
    logic [13:0] exp_q[$];

    // Reference model state: "dividing", "flush owed", stalled-cycle count.
    bit m_div;
    bit m_pend;
    bit m_to;
    int m_cnt;

    function automatic bit hits(input logic [4:0] w, input logic [4:0] a,
                                input logic [4:0] b);
        return (w != 5'd0) && (w == a || w == b);
    endfunction

    function automatic bit ref_dual();
        if (!(D_master_valid && D_slave_valid)) return 1'b0;
        if (D_master_reg_wen && hits(D_master_reg_waddr, D_slave_rs, D_slave_rt)) return 1'b0;
        if (E_master_memRead && hits(E_master_reg_waddr, D_slave_rs, D_slave_rt)) return 1'b0;
        if (D_master_mem_en && D_slave_mem_en) return 1'b0;
        if (D_master_hilo && D_slave_hilo) return 1'b0;
        if (D_slave_is_branch || D_slave_priv) return 1'b0;
        return 1'b1;
    endfunction

    // Compute expected outputs for the cycle whose inputs are now applied,
    // queue them, advance the model, then move to the next cycle.
    task automatic step();
        bit fe = 0, de = 0, dc = 0, e1 = 0, e2 = 0, c1 = 0, c2 = 0;
        bit me = 0, mc = 0, we = 0, di = 0;
        int cons = 0;
        bit stall_c = i_stall || d_stall;
        bit fnow = (M_except_flush || m_pend) && !stall_c;
        if (rst) begin
            dc = 1; c1 = 1; c2 = 1; mc = 1;
        end else if (fnow) begin
            dc = 1; c1 = 1; c2 = 1; mc = 1; fe = 1; we = 1;
        end else if (stall_c || m_div) begin
            cons = 0;
        end else if (E_master_memRead && hits(E_master_reg_waddr, D_master_rs, D_master_rt)) begin
            c1 = 1; c2 = 1; me = 1; we = 1;
        end else begin
            fe = 1; de = 1; e1 = 1; me = 1; we = 1;
            if (!D_master_valid) begin
                c1 = 1; c2 = 1; cons = 0;
            end else if (ref_dual()) begin
                e2 = 1; cons = 2; di = 1;
            end else begin
                c2 = 1; cons = 1;
            end
        end
        exp_q.push_back({fe, de, dc, e1, e2, c1, c2, me, mc, we, 2'(cons), di, m_to});

        if (rst) begin
            m_div = 0; m_pend = 0; m_to = 0; m_cnt = 0;
        end else if (fnow) begin
            m_div = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (M_except_flush && stall_c) m_pend = 1;
            if (!m_div) begin
                if (E_div_start && !stall_c) m_div = 1;
            end else if (div_done) begin
                m_div = 0; m_cnt = 0;
            end else begin
                if (m_cnt < c_DIV_MAX) m_cnt++;
                if (m_cnt == c_DIV_MAX) m_to = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0;
        D_master_valid = 1; D_slave_valid = 1;
        D_master_rs = 5'd1; D_master_rt = 5'd2;
        D_slave_rs = 5'd4;  D_slave_rt = 5'd5;
        D_master_reg_waddr = 5'd3; D_master_reg_wen = 1;
        D_master_mem_en = 0; D_slave_mem_en = 0;
        D_master_hilo = 0; D_slave_hilo = 0;
        D_slave_is_branch = 0; D_slave_priv = 0;
        E_master_memRead = 0; E_master_reg_waddr = 5'd0;
        E_div_start = 0; div_done = 0;
        i_stall = 0; d_stall = 0; M_except_flush = 0;
    endtask

    task automatic rand_inputs();
        rst                = ($urandom_range(0, 99) < 1);
        D_master_valid     = ($urandom_range(0, 9) < 9);
        D_slave_valid      = ($urandom_range(0, 9) < 8);
        D_master_rs        = 5'($urandom_range(0, 7));
        D_master_rt        = 5'($urandom_range(0, 7));
        D_slave_rs         = 5'($urandom_range(0, 7));
        D_slave_rt         = 5'($urandom_range(0, 7));
        D_master_reg_waddr = 5'($urandom_range(0, 7));
        D_master_reg_wen   = ($urandom_range(0, 9) < 7);
        D_master_mem_en    = ($urandom_range(0, 9) < 3);
        D_slave_mem_en     = ($urandom_range(0, 9) < 3);
        D_master_hilo      = ($urandom_range(0, 9) < 2);
        D_slave_hilo       = ($urandom_range(0, 9) < 2);
        D_slave_is_branch  = ($urandom_range(0, 99) < 15);
        D_slave_priv       = ($urandom_range(0, 99) < 10);
        E_master_memRead   = ($urandom_range(0, 9) < 3);
        E_master_reg_waddr = 5'($urandom_range(0, 7));
        E_div_start        = ($urandom_range(0, 99) < 5);
        div_done           = ($urandom_range(0, 99) < 12);
        i_stall            = ($urandom_range(0, 99) < 10);
        d_stall            = ($urandom_range(0, 99) < 10);
        M_except_flush     = ($urandom_range(0, 99) < 5);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    initial begin
        logic [13:0] e;
        logic [13:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {F_ena, D_ena, D_clear, ena1, ena2, clear1, clear2,
                       M_ena, M_clear, W_ena, D_consume, dual_issue, div_timeout};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl t=%0t actual=%b required=%b (F D Dc e1 e2 c1 c2 Me Mc We cons dual to)",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        m_div = 0; m_pend = 0; m_to = 0; m_cnt = 0;
        quiet();
        rst = 1;
        @(posedge clk);
        #1;
        step();                                  // reset cycle outputs
        quiet();

        // Independent pair, then slave RAW, then former slave in master slot.
        step();
        D_slave_rs = 5'd3; step();
        D_master_rs = 5'd3; D_master_rt = 5'd0; D_master_reg_waddr = 5'd6; D_slave_rs = 5'd8; step();
        quiet();

        // Load-use one cycle, then issue; waddr 0 never stalls.
        E_master_memRead = 1; E_master_reg_waddr = 5'd7; D_master_rt = 5'd7; step();
        quiet(); step();
        E_master_memRead = 1; E_master_reg_waddr = 5'd0; D_master_rt = 5'd0; step();
        quiet();

        // Divide completing after 10 stalled cycles.
        E_div_start = 1; step();
        E_div_start = 0;
        for (int i = 0; i < 9; i++) step();
        div_done = 1; step();
        div_done = 0; step(); step();

        // Divide that never completes: timeout, then flush clears DIV.
        E_div_start = 1; step();
        E_div_start = 0;
        for (int i = 0; i < 44; i++) step();
        M_except_flush = 1; step();
        M_except_flush = 0; step();

        // Exception during a 5-cycle data stall.
        d_stall = 1; M_except_flush = 1; step();
        M_except_flush = 0;
        for (int i = 0; i < 4; i++) step();
        d_stall = 0; step(); step();

        // Reset in the third DIV cycle.
        E_div_start = 1; step();
        E_div_start = 0; step(); step();
        rst = 1; step();
        rst = 0; step(); step();

        // Divide start during a cache stall is deferred.
        i_stall = 1; E_div_start = 1; step(); step();
        i_stall = 0; step();
        E_div_start = 0; step();
        div_done = 1; M_except_flush = 1; step();
        quiet(); step();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        quiet();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dual_issue_ctrl
`default_nettype wire
